// File: rtl/ser_40.sv
// ----------------------------------------------------------------------------
// ser_40 -- double-buffered 8-bit parallel-to-serial converter, LSB first.
//
// A word is accepted into a holding register. From there it moves into the
// shift register, which sends one bit per clock_40 edge on which enable is
// high. If the next word is already held when the last slot of a frame goes
// out, it is reloaded on that same edge, so back-to-back frames have no gap.
//
// Optional feature (compile-time macro SER_40_PARITY_EN):
//   defined   : 9-slot frame; slot 8 carries even parity (XOR of the 8 bits).
//   undefined : 8-slot frame, no parity logic. Ports are the same in both.
//
// Parameters:
//   IDLE_LEVEL      level on data_out while no frame bit is being sent
//
// Ports:
//   clock_40        in   1  clock, rising edge
//   reset           in   1  synchronous, active-high
//   enable          in   1  bit-slot strobe
//   word_in         in   8  parallel word
//   word_valid      in   1  word_in valid this cycle
//   word_ready      out  1  holding register empty (accept on valid && ready)
//   data_out        out  1  serial bit, registered
//   data_out_valid  out  1  high exactly when data_out carries a frame bit
//   busy            out  1  shifting or holding a word
// ----------------------------------------------------------------------------
module ser_40 #(
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic       clock_40,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] word_in,
   input  logic       word_valid,
   output logic       word_ready,
   output logic       data_out,
   output logic       data_out_valid,
   output logic       busy
);

`ifdef SER_40_PARITY_EN
   localparam logic [3:0] LAST = 4'd8;
`else
   localparam logic [3:0] LAST = 4'd7;
`endif

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] hold_q, hold_d;
   logic       hold_full_q, hold_full_d;
   logic [7:0] shreg_q, shreg_d;
   logic [3:0] cnt_q, cnt_d;
   logic       data_out_q, data_out_d;
   logic       data_out_valid_q, data_out_valid_d;
`ifdef SER_40_PARITY_EN
   logic       parity_q, parity_d;
`endif

   logic       accept;
   logic       next_bit;

   // Ready depends only on a register, so there is no combinational path
   // from word_valid back to word_ready.
   assign word_ready     = !hold_full_q;
   assign accept         = word_valid && !hold_full_q;
   assign data_out       = data_out_q;
   assign data_out_valid = data_out_valid_q;
   assign busy           = (state_q == SHIFT) || hold_full_q;

   // Bit for the current slot: data bits come from shreg[0]; the extra slot
   // of a parity frame comes from the parity captured at load time.
`ifdef SER_40_PARITY_EN
   assign next_bit = (cnt_q == LAST) ? parity_q : shreg_q[0];
`else
   assign next_bit = shreg_q[0];
`endif

   always_comb begin
      state_d          = state_q;
      hold_d           = hold_q;
      hold_full_d      = hold_full_q;
      shreg_d          = shreg_q;
      cnt_d            = cnt_q;
      data_out_d       = data_out_q;
      data_out_valid_d = 1'b0;
`ifdef SER_40_PARITY_EN
      parity_d         = parity_q;
`endif

      // Accept only fires with hold empty, and every move from hold into
      // shreg needs hold full, so the two never happen on the same edge.
      if (accept) begin
         hold_d      = word_in;
         hold_full_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            data_out_d = IDLE_LEVEL;
            // Transfer does not wait for enable; the first bit goes out on
            // the next enable-high edge.
            if (hold_full_q) begin
               shreg_d     = hold_q;
               hold_full_d = 1'b0;
               cnt_d       = 4'd0;
               state_d     = SHIFT;
`ifdef SER_40_PARITY_EN
               parity_d    = ^hold_q;
`endif
            end
         end

         SHIFT: begin
            // With enable low everything holds and data_out keeps its value.
            if (enable) begin
               data_out_d       = next_bit;
               data_out_valid_d = 1'b1;
               shreg_d          = shreg_q >> 1;
               cnt_d            = cnt_q + 4'd1;
               if (cnt_q == LAST) begin
                  cnt_d = 4'd0;
                  if (hold_full_q) begin
                     // Reload on the last slot so the next frame follows
                     // with no idle slot in between.
                     shreg_d     = hold_q;
                     hold_full_d = 1'b0;
`ifdef SER_40_PARITY_EN
                     parity_d    = ^hold_q;
`endif
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock_40) begin
      if (reset) begin
         state_q          <= IDLE;
         hold_q           <= 8'd0;
         hold_full_q      <= 1'b0;
         shreg_q          <= 8'd0;
         cnt_q            <= 4'd0;
         data_out_q       <= IDLE_LEVEL;
         data_out_valid_q <= 1'b0;
`ifdef SER_40_PARITY_EN
         parity_q         <= 1'b0;
`endif
      end else begin
         state_q          <= state_d;
         hold_q           <= hold_d;
         hold_full_q      <= hold_full_d;
         shreg_q          <= shreg_d;
         cnt_q            <= cnt_d;
         data_out_q       <= data_out_d;
         data_out_valid_q <= data_out_valid_d;
`ifdef SER_40_PARITY_EN
         parity_q         <= parity_d;
`endif
      end
   end

endmodule

// File: doc/ser_40.md
SER_40 -- requirements
Module: ser_40

Interface
REQ-001 Parameter IDLE_LEVEL, default 1'b0: level driven on data_out when no bit is being transmitted.
REQ-002 clock_40  input  1  sampling clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 enable  input  1  bit-slot strobe; one serial bit advances per clock_40 edge with enable high.
REQ-005 word_in  input  8  parallel word to serialize.
REQ-006 word_valid  input  1  word_in is valid this cycle.
REQ-007 word_ready  output  1  holding register empty; word accepted on an edge with word_valid && word_ready.
REQ-008 data_out  output  1  serial bit, registered.
REQ-009 data_out_valid  output  1  registered; high for exactly the cycles data_out carries a frame bit.
REQ-010 busy  output  1  high while state is SHIFT or the holding register is full.

Function
REQ-011 Double-buffered: 8-bit holding register (hold, hold_full) feeding 8-bit shift register (shreg), bit counter cnt[3:0].
REQ-012 word_ready = !hold_full (combinational from a register); a word presented while word_ready is low is not accepted and word_valid is ignored.
REQ-013 Accept edge: hold <= word_in, hold_full <= 1.
REQ-014 States: IDLE, SHIFT.
REQ-015 IDLE: if hold_full, shreg <= hold, hold_full <= 0, cnt <= 0, state <= SHIFT on that edge, independent of enable; data_out <= IDLE_LEVEL, data_out_valid <= 0.
REQ-016 SHIFT, enable high: data_out <= shreg[0], data_out_valid <= 1, shreg <= shreg >> 1, cnt <= cnt + 1 (LSB first, bit 0 first).
REQ-017 SHIFT, enable low: shreg, cnt unchanged; data_out holds last value; data_out_valid <= 0.
REQ-018 Last slot (cnt == LAST, enable high): if hold_full, reload shreg from hold, clear hold_full, cnt <= 0, stay in SHIFT (no gap slot); else state <= IDLE.
REQ-019 LAST = 7 without parity feature (8-slot frame).
REQ-020 Latency: word accepted at edge N from IDLE -> transfer at edge N+1 -> first bit registered at first enable-high edge >= N+2.
REQ-021 Accept and transfer never coincide on the same edge (word_ready low while hold_full).
REQ-022 Back-to-back words with enable held high produce contiguous data_out_valid with no idle slot.

Reset
REQ-023 On reset: state IDLE, hold_full 0, hold 0, shreg 0, cnt 0, data_out IDLE_LEVEL, data_out_valid 0; word_ready 1 and busy 0 on the first cycle after.
REQ-024 Reset mid-frame aborts the frame and discards any held word; no partial bits follow reset release.
REQ-025 Reset takes priority over enable and word_valid in the same cycle.

Configuration
REQ-026 Macro SER_40_PARITY_EN defined: LAST = 8; slot 8 transmits even parity (XOR of the 8 data bits) from a parity register captured at shreg load; 9-slot frame; reload rule of REQ-018 applies after slot 8.
REQ-027 Macro SER_40_PARITY_EN undefined: no parity logic; 8-slot frame; ports identical in both builds.

Verification
REQ-028 Reset, enable=1, send 8'hA5 -> data_out = 1,0,1,0,0,1,0,1 on 8 consecutive valid slots, then data_out_valid 0, busy 0.
REQ-029 Send 8'h01 then 8'h80 back to back, enable=1 -> 16 contiguous valid slots: 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1; word_ready low while second word is held.
REQ-030 enable high one cycle in four, send 8'h3C -> 8 valid slots, each 4 cycles apart, bits 0,0,1,1,1,1,0,0; data_out_valid low between slots.
REQ-031 Send 8'hFF, assert reset after slot 3 -> data_out_valid 0 and data_out IDLE_LEVEL from the next edge; no further valid slots; word_ready 1.
REQ-032 Present word_valid with 8'h55 while word_ready=0 -> word not accepted; only previously held word transmitted.
REQ-033 With SER_40_PARITY_EN, send 8'h07 -> slots 1,1,1,0,0,0,0,0 then parity slot 1; with 8'h03 -> parity slot 0.
